// File: rtl/mem_access_if.sv
// Data-bus interface between the MEM-stage load/store unit and the data memory.
// The unit drives a req/ack transaction with word address, byte enables and write data.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-stage load/store unit: one req/ack bus transaction per load/store.
// Optional MEM_ACCESS_MISALIGN_CHECK_EN drops misaligned halfword/word ops and pulses misalign_o.
//
// state | meaning
// IDLE  | accept memory op, or pass non-memory result through in one cycle
// BUSY  | bus request held until ack; result written on the ack edge
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [2:0]  ex_size_i,
    input  logic        ex_we_i,
    input  logic        ex_re_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_reg_wen_i,
    input  logic [31:0] ex_alu_data_i,
    output logic        stall_o,
    output logic [31:0] mem_rd_data_o,
    output logic [4:0]  mem_rd_addr_o,
    output logic        mem_reg_wen_o,
    output logic        misalign_o,
    mem_access_if.master bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        mem_op, size_ok, misaligned, accept;
    logic [1:0]  lane;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic        wen_q;

    assign lane   = ex_addr_i[1:0];
    assign mem_op = ex_valid_i & (ex_we_i | ex_re_i);

    always_comb begin
        size_ok = 1'b0;
        case (ex_size_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign misaligned = mem_op & size_ok &
                        (((ex_size_i[1:0] == 2'b01) & lane[0]) |
                         ((ex_size_i[1:0] == 2'b10) & (lane != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state == IDLE) & mem_op & size_ok & ~misaligned;

    // Store lanes; halfword lane choice uses only a[1], so unaligned halves fall back to aligned lanes.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = ex_wdata_i;
        if (ex_we_i) begin
            case (ex_size_i[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << lane;
                    wdata_nxt = {4{ex_wdata_i[7:0]}};
                end
                2'b01: begin
                    be_nxt    = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{ex_wdata_i[15:0]}};
                end
                default: be_nxt = 4'b1111;
            endcase
        end
    end

    always_comb begin
        byte_sel = bus.rdata[7:0];
        case (lane_q)
            2'b00:   byte_sel = bus.rdata[7:0];
            2'b01:   byte_sel = bus.rdata[15:8];
            2'b10:   byte_sel = bus.rdata[23:16];
            default: byte_sel = bus.rdata[31:24];
        endcase
        half_sel = lane_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (size_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = bus.rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    stall_o   = 1'b1;
                end
            end
            BUSY: begin
                if (bus.ack) state_nxt = IDLE;
                else         stall_o   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) stall_o = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            be_q          <= 4'b0000;
            size_q        <= 3'd0;
            lane_q        <= 2'd0;
            rd_q          <= 5'd0;
            wen_q         <= 1'b0;
            mem_rd_data_o <= 32'd0;
            mem_rd_addr_o <= 5'd0;
            mem_reg_wen_o <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    we_q          <= ex_we_i;
                    addr_q        <= {ex_addr_i[31:2], 2'b00};
                    wdata_q       <= wdata_nxt;
                    be_q          <= be_nxt;
                    size_q        <= ex_size_i;
                    lane_q        <= lane;
                    rd_q          <= ex_rd_addr_i;
                    wen_q         <= ex_reg_wen_i;
                    mem_reg_wen_o <= 1'b0;
                end else if (ex_valid_i & ~(ex_we_i | ex_re_i)) begin
                    mem_rd_data_o <= ex_alu_data_i;
                    mem_rd_addr_o <= ex_rd_addr_i;
                    mem_reg_wen_o <= ex_reg_wen_i;
                end else begin
                    mem_reg_wen_o <= 1'b0;
                    misalign_o    <= misaligned;
                end
            end else if (bus.ack) begin
                mem_rd_addr_o <= rd_q;
                if (we_q) begin
                    mem_rd_data_o <= 32'd0;
                    mem_reg_wen_o <= 1'b0;
                end else begin
                    mem_rd_data_o <= load_data;
                    mem_reg_wen_o <= wen_q;
                end
            end else begin
                mem_reg_wen_o <= 1'b0;
            end
        end
    end

    // req comes straight from the state register so an async reset drops it at once.
    assign bus.req   = (state == BUSY);
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus transactions and results,
// monitors pop and compare whenever the DUT raises bus.req or mem_reg_wen_o.
`timescale 1ns/1ps
module tb_mem_access;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [31:0] ex_addr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic [2:0]  ex_size_i = '0;
    logic        ex_we_i = 1'b0;
    logic        ex_re_i = 1'b0;
    logic [4:0]  ex_rd_addr_i = '0;
    logic        ex_reg_wen_i = 1'b0;
    logic [31:0] ex_alu_data_i = '0;
    logic        stall_o;
    logic [31:0] mem_rd_data_o;
    logic [4:0]  mem_rd_addr_o;
    logic        mem_reg_wen_o;
    logic        misalign_o;

    mem_access_if bus_if ();

    mem_access dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid_i),
        .ex_addr_i     (ex_addr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_size_i     (ex_size_i),
        .ex_we_i       (ex_we_i),
        .ex_re_i       (ex_re_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_reg_wen_i  (ex_reg_wen_i),
        .ex_alu_data_i (ex_alu_data_i),
        .stall_o       (stall_o),
        .mem_rd_data_o (mem_rd_data_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_reg_wen_o (mem_reg_wen_o),
        .misalign_o    (misalign_o),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   misalign_seen = 0;
    res_t res_q[$];
    bus_t bus_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compare bus transactions on req rising and results whenever wen is high.
    initial begin
        logic req_prev;
        bus_t b;
        res_t r;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
            end else begin
                if (bus_if.req && !req_prev) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_bus_req", 32'd1, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_we", {31'd0, bus_if.we}, {31'd0, b.we});
                        chk("bus_addr", bus_if.addr, b.addr);
                        chk("bus_be", {28'd0, bus_if.be}, {28'd0, b.be});
                        if (b.we) chk("bus_wdata", bus_if.wdata, b.wdata);
                    end
                end
                req_prev = bus_if.req;
                if (mem_reg_wen_o) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_wen", 32'd1, 32'd0);
                    end else begin
                        r = res_q.pop_front();
                        chk("rd_data", mem_rd_data_o, r.data);
                        chk("rd_addr", {27'd0, mem_rd_addr_o}, {27'd0, r.rd});
                        chk("result_cycle", cyc, r.cyc);
                    end
                end
                if (misalign_o) misalign_seen++;
            end
        end
    end

    task automatic drive_mem(input logic [2:0] size, input logic we, input logic re,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input logic wen);
        ex_valid_i   = 1'b1;
        ex_size_i    = size;
        ex_we_i      = we;
        ex_re_i      = re;
        ex_addr_i    = addr;
        ex_wdata_i   = wdata;
        ex_rd_addr_i = rd;
        ex_reg_wen_i = wen;
    endtask

    // Entered and left at posedge+1.
    task automatic mem_op(input string name, input logic [2:0] size, input logic we, input logic re,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic wen, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be);
        int stall_n;
        bus_t b;
        res_t r;
        b.we = we; b.addr = exp_addr; b.wdata = exp_wdata; b.be = exp_be;
        bus_q.push_back(b);
        if (!we && wen) begin
            r.data = exp_data; r.rd = rd; r.cyc = cyc + 2 + waits;
            res_q.push_back(r);
        end
        drive_mem(size, we, re, addr, wdata, rd, wen);
        stall_n = 0;
        bus_if.rdata = 32'hBAD0BAD0;
        @(negedge clk); if (stall_o) stall_n++;
        @(posedge clk); #1;
        for (int k = 0; k < waits; k++) begin
            @(negedge clk); if (stall_o) stall_n++;
            @(posedge clk); #1;
        end
        bus_if.ack   = 1'b1;
        bus_if.rdata = rdata;
        @(negedge clk); if (stall_o) stall_n++;
        @(posedge clk); #1;
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'hBAD0BAD0;
        ex_valid_i   = 1'b0;
        @(negedge clk);
        chk({name, "_req_drop"}, {31'd0, bus_if.req}, 32'd0);
        chk({name, "_stall_cycles"}, stall_n, waits + 1);
        if (we) begin
            chk({name, "_store_wen"}, {31'd0, mem_reg_wen_o}, 32'd0);
            chk({name, "_store_data"}, mem_rd_data_o, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic alu_op(input logic [31:0] data, input logic [4:0] rd, input logic wen);
        res_t r;
        if (wen) begin
            r.data = data; r.rd = rd; r.cyc = cyc + 1;
            res_q.push_back(r);
        end
        ex_valid_i    = 1'b1;
        ex_we_i       = 1'b0;
        ex_re_i       = 1'b0;
        ex_alu_data_i = data;
        ex_rd_addr_i  = rd;
        ex_reg_wen_i  = wen;
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
    endtask

    // Op that must produce no bus activity and wen 0 on the next edge.
    task automatic quiet_op(input string name, input logic valid, input logic [2:0] size,
                            input logic we, input logic re, input logic [31:0] addr,
                            input logic ack);
        drive_mem(size, we, re, addr, 32'h0000_00FF, 5'd9, 1'b1);
        ex_valid_i = valid;
        bus_if.ack = ack;
        @(negedge clk);
        chk({name, "_stall"}, {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        bus_if.ack = 1'b0;
        @(negedge clk);
        chk({name, "_wen"}, {31'd0, mem_reg_wen_o}, 32'd0);
        chk({name, "_req"}, {31'd0, bus_if.req}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'd0;
        drive_mem(3'b010, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 5'd1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, bus_if.req}, 32'd0);
        chk("rst_we", {31'd0, bus_if.we}, 32'd0);
        chk("rst_addr", bus_if.addr, 32'd0);
        chk("rst_wdata", bus_if.wdata, 32'd0);
        chk("rst_be", {28'd0, bus_if.be}, 32'd0);
        chk("rst_rd_data", mem_rd_data_o, 32'd0);
        chk("rst_rd_addr", {27'd0, mem_rd_addr_o}, 32'd0);
        chk("rst_wen", {31'd0, mem_reg_wen_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        ex_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem_op("sb", 3'b000, 1'b1, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd0, 1'b0, 3,
               32'd0, 32'd0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        mem_op("lb", 3'b000, 1'b0, 1'b1, 32'h0000_2002, 32'd0, 5'd5, 1'b1, 0,
               32'h12F0_3456, 32'hFFFF_FFF0, 32'h0000_2000, 32'd0, 4'b1111);
        mem_op("lbu", 3'b100, 1'b0, 1'b1, 32'h0000_2002, 32'd0, 5'd5, 1'b1, 0,
               32'h12F0_3456, 32'h0000_00F0, 32'h0000_2000, 32'd0, 4'b1111);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        quiet_op("lh_mis", 1'b1, 3'b001, 1'b0, 1'b1, 32'h0000_2001, 1'b0);
        chk("misalign_pulse", misalign_seen, 1);
`else
        mem_op("lh_a1", 3'b001, 1'b0, 1'b1, 32'h0000_2001, 32'd0, 5'd6, 1'b1, 0,
               32'h8001_ABCD, 32'hFFFF_ABCD, 32'h0000_2000, 32'd0, 4'b1111);
`endif

        alu_op(32'hDEAD_BEEF, 5'd3, 1'b1);
        mem_op("lw", 3'b010, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 5'd7, 1'b1, 1,
               32'h1122_3344, 32'h1122_3344, 32'h0000_0010, 32'd0, 4'b1111);

        quiet_op("idle_ack", 1'b0, 3'b010, 1'b0, 1'b1, 32'h0000_0020, 1'b1);
        mem_op("sh", 3'b001, 1'b1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 1'b0, 0,
               32'd0, 32'd0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        mem_op("sw_both", 3'b010, 1'b1, 1'b1, 32'h0000_0030, 32'h1234_5678, 5'd8, 1'b1, 2,
               32'd0, 32'd0, 32'h0000_0030, 32'h1234_5678, 4'b1111);
        mem_op("lhu", 3'b101, 1'b0, 1'b1, 32'h0000_0042, 32'd0, 5'd10, 1'b1, 0,
               32'h8001_ABCD, 32'h0000_8001, 32'h0000_0040, 32'd0, 4'b1111);
        mem_op("lh_hi", 3'b001, 1'b0, 1'b1, 32'h0000_0042, 32'd0, 5'd11, 1'b1, 1,
               32'h8001_ABCD, 32'hFFFF_8001, 32'h0000_0040, 32'd0, 4'b1111);
        mem_op("lb_nowen", 3'b000, 1'b0, 1'b1, 32'h0000_0041, 32'd0, 5'd12, 1'b0, 0,
               32'h0000_8000, 32'd0, 32'h0000_0040, 32'd0, 4'b1111);

        alu_op(32'h0000_0055, 5'd4, 1'b1);
        quiet_op("illegal_size", 1'b1, 3'b011, 1'b0, 1'b1, 32'h0000_0050, 1'b0);
        alu_op(32'h0000_0066, 5'd4, 1'b1);
        quiet_op("invalid", 1'b0, 3'b010, 1'b1, 1'b0, 32'h0000_0050, 1'b0);
        alu_op(32'h0000_0077, 5'd2, 1'b0);

        begin
            bus_t b;
            b.we = 1'b0; b.addr = 32'h0000_0060; b.wdata = 32'd0; b.be = 4'b1111;
            bus_q.push_back(b);
            drive_mem(3'b010, 1'b0, 1'b1, 32'h0000_0060, 32'd0, 5'd13, 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_req", {31'd0, bus_if.req}, 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_busy_req", {31'd0, bus_if.req}, 32'd0);
            chk("rst_busy_stall", {31'd0, stall_o}, 32'd0);
            ex_valid_i = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("post_rst_req", {31'd0, bus_if.req}, 32'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("bus_q_empty", bus_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
`ifndef MEM_ACCESS_MISALIGN_CHECK_EN
        chk("misalign_never", misalign_seen, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
